// File: rtl/ready_and_link_pkg.sv
// Shared direction encoding and dimension-ordered route computation for
// the ready-and mesh router.
package ready_and_link_pkg;

  typedef enum logic [2:0] {
    p_e = 3'd0,
    w_e = 3'd1,
    e_e = 3'd2,
    n_e = 3'd3,
    s_e = 3'd4
  } dir_e;

  localparam int DIRS       = 5;
  localparam int MAX_CORD_W = 16;

  // X is resolved first, then Y; equal coordinates on both axes deliver locally.
  function automatic dir_e xy_route(input logic [MAX_CORD_W-1:0] dx,
                                    input logic [MAX_CORD_W-1:0] dy,
                                    input logic [MAX_CORD_W-1:0] my_x,
                                    input logic [MAX_CORD_W-1:0] my_y);
    if (dx > my_x) return e_e;
    if (dx < my_x) return w_e;
    if (dy > my_y) return s_e;
    if (dy < my_y) return n_e;
    return p_e;
  endfunction

endpackage

// File: rtl/ready_and_fifo.sv
// Small input buffer with a combinational head view; depth need not be a
// power of two.
module ready_and_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ready_and_mesh_router.sv
// Five-port single-flit mesh router: buffered inputs, XY routing and a
// round-robin arbiter per output with ready-and flow control.
module ready_and_mesh_router
  import ready_and_link_pkg::*;
#(
  parameter int           DATA_W     = 66,
  parameter int           X_CORD_W   = 4,
  parameter int           Y_CORD_W   = 4,
  parameter int           FIFO_DEPTH = 2,
  parameter logic [4:0]   DIR_EN     = 5'b11111
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [X_CORD_W-1:0]           my_x_i,
  input  logic [Y_CORD_W-1:0]           my_y_i,
  input  logic [DIRS-1:0][DATA_W+1:0]   link_i,
  output logic [DIRS-1:0][DATA_W+1:0]   link_o,
  output logic [DIRS-1:0]               err_o
);

  typedef struct packed {
    logic              v;
    logic              ready_and_rev;
    logic [DATA_W-1:0] data;
  } link_s;

  link_s [DIRS-1:0]  in_s, out_s;
  logic [DIRS-1:0]   empty, full, push, pop, drop, in_rdy, gnt_v;
  logic [DATA_W-1:0] head [DIRS];
  dir_e              route [DIRS];
  logic [2:0]        gnt_idx [DIRS];
  logic [2:0]        rr_q [DIRS], rr_d [DIRS];
  logic [2:0]        hold_idx_q [DIRS], hold_idx_d [DIRS];
  logic [DIRS-1:0]   hold_q, hold_d, err_q, err_d;
  logic              live_q;

  assign in_s   = link_i;
  assign link_o = out_s;
  assign err_o  = err_q;

  for (genvar gi = 0; gi < DIRS; gi++) begin : g_in
    // live_q keeps every ready low until the first edge after reset release.
    assign in_rdy[gi] = DIR_EN[gi] && live_q && !full[gi];
    assign push[gi]   = in_s[gi].v && in_rdy[gi];

    if (DIR_EN[gi]) begin : g_fifo
      ready_and_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push[gi]),
        .data_i    (in_s[gi].data),
        .pop_i     (pop[gi]),
        .data_o    (head[gi]),
        .empty_o   (empty[gi]),
        .full_o    (full[gi])
      );
    end else begin : g_off
      assign head[gi]  = '0;
      assign empty[gi] = 1'b1;
      assign full[gi]  = 1'b0;
    end

    assign route[gi] = xy_route(MAX_CORD_W'(head[gi][X_CORD_W-1:0]),
                                MAX_CORD_W'(head[gi][X_CORD_W+Y_CORD_W-1:X_CORD_W]),
                                MAX_CORD_W'(my_x_i), MAX_CORD_W'(my_y_i));
    assign drop[gi]  = !empty[gi] && !DIR_EN[route[gi]];
  end

  // Scan from the pointer downwards so the nearest requester wins last.
  always_comb begin
    int c;
    c = 0;
    for (int o = 0; o < DIRS; o++) begin
      gnt_v[o]   = 1'b0;
      gnt_idx[o] = hold_idx_q[o];
      if (hold_q[o]) begin
        gnt_v[o] = 1'b1;
      end else if (DIR_EN[o]) begin
        for (int k = DIRS - 1; k >= 0; k--) begin
          c = int'(rr_q[o]) + k;
          if (c >= DIRS) c = c - DIRS;
          if (!empty[c] && route[c] == dir_e'(o)) begin
            gnt_v[o]   = 1'b1;
            gnt_idx[o] = 3'(c);
          end
        end
      end
    end
  end

  always_comb begin
    pop   = drop;
    err_d = err_q | drop;
    out_s = '0;
    for (int o = 0; o < DIRS; o++) begin
      out_s[o].v             = gnt_v[o];
      out_s[o].ready_and_rev = in_rdy[o];
      out_s[o].data          = gnt_v[o] ? head[gnt_idx[o]] : '0;
      hold_d[o]              = gnt_v[o] && !in_s[o].ready_and_rev;
      hold_idx_d[o]          = gnt_idx[o];
      rr_d[o]                = rr_q[o];
      if (gnt_v[o] && in_s[o].ready_and_rev) begin
        pop[gnt_idx[o]] = 1'b1;
        rr_d[o] = (gnt_idx[o] == 3'(s_e)) ? 3'(p_e) : gnt_idx[o] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live_q <= 1'b0;
      err_q  <= '0;
      hold_q <= '0;
      for (int o = 0; o < DIRS; o++) begin
        rr_q[o]       <= 3'(p_e);
        hold_idx_q[o] <= 3'(p_e);
      end
    end else begin
      live_q <= 1'b1;
      err_q  <= err_d;
      hold_q <= hold_d;
      for (int o = 0; o < DIRS; o++) begin
        rr_q[o]       <= rr_d[o];
        hold_idx_q[o] <= hold_idx_d[o];
      end
    end
  end

endmodule
